// File: rtl/muldiv_unit_pkg.sv
// Shared ALU control codes, FSM encoding and op-class helpers
// for the EX-stage HI/LO multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [7:0] MULT_CONTROL  = 8'h40;
  localparam logic [7:0] MULTU_CONTROL = 8'h41;
  localparam logic [7:0] DIV_CONTROL   = 8'h42;
  localparam logic [7:0] DIVU_CONTROL  = 8'h43;
  localparam logic [7:0] MADD_CONTROL  = 8'h44;
  localparam logic [7:0] MADDU_CONTROL = 8'h45;
  localparam logic [7:0] MSUB_CONTROL  = 8'h46;
  localparam logic [7:0] MSUBU_CONTROL = 8'h47;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } md_state_t;

  function automatic logic op_div(input logic [7:0] op);
    return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
  endfunction

  function automatic logic op_madd(input logic [7:0] op);
    return (op == MADD_CONTROL) || (op == MADDU_CONTROL);
  endfunction

  function automatic logic op_msub(input logic [7:0] op);
    return (op == MSUB_CONTROL) || (op == MSUBU_CONTROL);
  endfunction

  function automatic logic op_valid(input logic [7:0] op);
    return op_div(op) || op_madd(op) || op_msub(op) ||
           (op == MULT_CONTROL) || (op == MULTU_CONTROL);
  endfunction

  function automatic logic op_signed(input logic [7:0] op);
    return (op == MULT_CONTROL) || (op == DIV_CONTROL) ||
           (op == MADD_CONTROL) || (op == MSUB_CONTROL);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Magnitude restoring divider, one quotient bit per cycle.
// quot/rem show the result of the step taken at the coming edge.
module div_iter #(
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [W-1:0]             dividend,
  input  logic [W-1:0]             divisor,
  output logic [$clog2(W+1)-1:0]   count,
  output logic [W-1:0]             quot,
  output logic [W-1:0]             rem
);
  localparam int CW = $clog2(W+1);

  logic [W-1:0]  q_r;
  logic [W-1:0]  r_r;
  logic [W-1:0]  d_r;
  logic [CW-1:0] cnt_r;
  logic [W:0]    sh;
  logic [W:0]    diff;
  logic          ge;

  always_comb begin
    sh   = {r_r, q_r[W-1]};
    diff = sh - {1'b0, d_r};
    ge   = ~diff[W];
    quot = {q_r[W-2:0], ge};
    rem  = ge ? diff[W-1:0] : sh[W-1:0];
  end

  assign count = cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= '0;
      r_r   <= '0;
      d_r   <= '0;
      cnt_r <= '0;
    end else if (load) begin
      q_r   <= dividend;
      r_r   <= '0;
      d_r   <= divisor;
      cnt_r <= CW'(W);
    end else if (cnt_r != '0) begin
      q_r   <= quot;
      r_r   <= rem;
      cnt_r <= cnt_r - CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO unit: pipelined 33x33 multiply/accumulate
// and an iterative divider, one op in flight, busy until done.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_i,
  input  logic [7:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int W2 = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int MW = $clog2(MUL_LAT + 1);
  localparam logic [MW-1:0] MC0 =
    MW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  md_state_t         state;
  logic [MW-1:0]     mcnt;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              sgn_r;
  logic              accept;
  logic              sgn_i;

  assign accept = start_i & ~busy_o & op_valid(op_i);
  assign sgn_i  = op_signed(op_i);

  logic signed [DATA_W:0] ma;
  logic signed [DATA_W:0] mb;
  logic [W2-1:0]          mprod;
  logic [W2-1:0]          mul_now;
  logic [W2-1:0]          mul_res;

  always_comb begin
    ma    = {sgn_i & a_i[DATA_W-1], a_i};
    mb    = {sgn_i & b_i[DATA_W-1], b_i};
    mprod = W2'(ma) * W2'(mb);
    unique case (1'b1)
      op_madd(op_i): mul_now = {hi_i, lo_i} + mprod;
      op_msub(op_i): mul_now = {hi_i, lo_i} - mprod;
      default:       mul_now = mprod;
    endcase
  end

  if (MUL_LAT == 1) begin : g_l1
    assign mul_res = mul_now;
  end else begin : g_pipe
    logic [W2-1:0] pipe [MUL_LAT-1];
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < MUL_LAT - 1; i++) pipe[i] <= '0;
      end else begin
        if (accept) pipe[0] <= mul_now;
        for (int i = 1; i < MUL_LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign mul_res = pipe[MUL_LAT-2];
  end

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvs;
  logic [CW-1:0]     dcnt;
  logic [DATA_W-1:0] dq;
  logic [DATA_W-1:0] dr;

  assign a_neg = sgn_i & a_i[DATA_W-1];
  assign b_neg = sgn_i & b_i[DATA_W-1];
  assign dvd   = a_neg ? -a_i : a_i;
  assign dvs   = b_neg ? -b_i : b_i;

  div_iter #(.W(DATA_W)) u_div (
    .clk      (clk),
    .rst_n    (resetn),
    .load     (accept & op_div(op_i)),
    .dividend (dvd),
    .divisor  (dvs),
    .count    (dcnt),
    .quot     (dq),
    .rem      (dr)
  );

  // Signed fix-up on the final step; divide-by-zero has a fixed answer.
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] div_lo;
  logic              neg_q;
  logic              neg_r;

  always_comb begin
    neg_q = sgn_r & (a_r[DATA_W-1] ^ b_r[DATA_W-1]);
    neg_r = sgn_r & a_r[DATA_W-1];
    if (b_r == '0) begin
      div_hi = a_r;
      div_lo = {DATA_W{1'b1}};
    end else begin
      div_hi = neg_r ? -dr : dr;
      div_lo = neg_q ? -dq : dq;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      mcnt   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      sgn_r  <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else if (flush_i) begin
      state  <= S_IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: if (accept) begin
          busy_o <= 1'b1;
          a_r    <= a_i;
          b_r    <= b_i;
          sgn_r  <= sgn_i;
          if (op_div(op_i)) begin
            state <= S_DIV;
          end else if (MUL_LAT == 1) begin
            state        <= S_DONE;
            done_o       <= 1'b1;
            {hi_o, lo_o} <= mul_res;
          end else begin
            state <= S_MUL;
            mcnt  <= MC0;
          end
        end
        S_MUL: if (mcnt == '0) begin
          state        <= S_DONE;
          done_o       <= 1'b1;
          {hi_o, lo_o} <= mul_res;
        end else begin
          mcnt <= mcnt - MW'(1);
        end
        S_DIV: if (dcnt == CW'(1)) begin
          state  <= S_DONE;
          done_o <= 1'b1;
          hi_o   <= div_hi;
          lo_o   <= div_lo;
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
